r200dmem_resp: RTL and testbench
================================

# r200dmem_resp

Data-memory responder for the r200 pipeline's MEM stage. Accepts one load or store request at a time over a valid/ready handshake and holds it for a configurable number of wait states. It then returns a response with load data, sign- or zero-extended per RV32I `func3`, or a store acknowledge. Misaligned, out-of-range and illegal-`func3` accesses get an error response and have no side effects.

## Interface
Parameters:
- `DEPTH`, 1024: memory size in 32-bit words; power of two.
- `WAIT`, 2: wait-state cycles between accept and response; 0–15.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_func3`  in  3  RV32I width/sign code.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (`rs2o`).
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes response.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  access faulted; no memory change.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid` & `req_ready`, latch we, func3, addr, wdata.
  - Go to WAIT with counter = WAIT−1, or directly to RESP if WAIT = 0.
- **WAIT**
  - `req_ready` = 0.
  - Counter decrements each cycle; at 0, go to RESP on the next edge.
- **Transition into RESP**
  - Perform the access on this edge.
  - Store: byte-enabled write of the aligned lane(s).
  - Load: capture the extended result into `resp_rdata`.
  - Set `resp_err`.
- **RESP**
  - `resp_valid` = 1; data and err are held stable until `resp_ready`.
  - On `resp_ready`, return to IDLE.
- **Loads**
  - 000 lb and 100 lbu: byte at `addr[1:0]`.
  - 001 lh and 101 lhu: half at `addr[1]`.
  - 010 lw: full word.
  - Signed codes sign-extend bit 7 or 15; unsigned codes zero-extend.
- **Stores**
  - 000 sb: `wdata[7:0]` to lane `addr[1:0]`.
  - 001 sh: `wdata[15:0]` to half `addr[1]`.
  - 010 sw: full word.
  - Other bytes of the word are unchanged.
- **Error conditions.** `resp_err` = 1 if any of the following holds:
  - half access with `addr[0]` = 1;
  - word access with `addr[1:0]` ≠ 0;
  - `addr` ≥ DEPTH·4;
  - load func3 ∈ {011, 110, 111};
  - store func3 ∉ {000, 001, 010}.
- **Error behaviour:** no write, `resp_rdata` = 0.
- Word index = `addr[log2(DEPTH)+1:2]`.
- Memory contents are not cleared by reset.

## Timing
- **Reset** (`rst` = 0 at an edge):
  - state = IDLE;
  - `req_ready` = 0 while `rst` = 0, 1 from the first cycle after release;
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
- **Latency:** accept edge to first `resp_valid` cycle = WAIT+1 cycles.
- **Throughput:**
  - one request per WAIT+2 cycles with `resp_ready` tied high;
  - no accept in RESP, even when `resp_ready` = 1.
- `resp_valid` with `resp_ready` low: hold indefinitely; `req_ready` stays 0.
- Read-after-write to the same address in the next request returns the new data.
- **Reset mid-operation:**
  - reset in WAIT drops the request; a pending store is not written;
  - reset in RESP drops the response; a store already written remains.
- The latched request is immune to input changes after accept.

## Structure
- `cpu.vh` gains `define`s:
  - load func3: LB, LH, LW, LBU, LHU;
  - store func3: SB, SH, SW;
  - FSM state encodings.
- One sub-module, `r200lsu_align` (combinational), containing:
  - load extraction and sign/zero extension;
  - store lane and byte-enable generation;
  - misalignment and illegal-func3 detection.
- The top holds the FSM, wait counter, word RAM and response registers.

## Test plan
- **Store word, then load word** (WAIT=2): sw 0xDEADBEEF @0x10, then lw @0x10.
  - Required: `resp_rdata` = 0xDEADBEEF, `err` = 0.
  - Required: `resp_valid` 3 cycles after each accept.
- **Byte store and signed/unsigned byte load:** sw 0x00000000 @0x20, sb 0x80 @0x21.
  - Required: lb @0x21 returns 0xFFFFFF80.
  - Required: lbu @0x21 returns 0x00000080.
  - Required: lw @0x20 returns 0x00008000.
- **Misaligned word store:** sw 0x12345678 @0x22.
  - Required: `err` = 1, `rdata` = 0.
  - Required: subsequent lw @0x20 still returns 0x00008000.
- **Out of range** (DEPTH=1024): lw @0x1000.
  - Required: `err` = 1.
- **Illegal func3:** load with func3 = 011.
  - Required: `err` = 1.
- **Backpressure** (WAIT=0): hold `resp_ready` = 0 for 5 cycles.
  - Required: `resp_valid`, `rdata` and `err` stable throughout, and `req_ready` = 0.
  - Required: one cycle after `resp_ready` = 1, `req_ready` = 1.
- **Reset in WAIT:** sw 0xAAAAAAAA @0x40, with 0x40 previously 0x11111111; reset asserted during WAIT.
  - Required: after release, lw @0x40 returns 0x11111111.
  - Required: `resp_valid` = 0 throughout reset.

Source files
------------

// File: rtl/r200dmem_resp_pkg.sv
// Shared encodings for the r200 data-memory responder: RV32I load/store func3 codes,
// FSM states and the latched request record.
package r200dmem_resp_pkg;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/r200lsu_align.sv
// Combinational lane logic: load extraction/extension, store lane replication and
// byte enables, plus misalignment and illegal-func3 detection.
module r200lsu_align
    import r200dmem_resp_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic [3:0]  store_be,
    output logic        align_err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = rword[7:0];
            2'd1: byte_sel = rword[15:8];
            2'd2: byte_sel = rword[23:16];
            2'd3: byte_sel = rword[31:24];
            default: byte_sel = rword[7:0];
        endcase
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        load_data  = '0;
        store_word = '0;
        store_be   = '0;
        align_err  = 1'b0;
        if (we) begin
            // Store data is replicated across lanes; the byte enables pick the live lane.
            case (func3)
                F3Sb: begin
                    store_word = {4{wdata[7:0]}};
                    store_be   = 4'b0001 << addr_lo;
                end
                F3Sh: begin
                    store_word = {2{wdata[15:0]}};
                    store_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
                    align_err  = addr_lo[0];
                end
                F3Sw: begin
                    store_word = wdata;
                    store_be   = 4'b1111;
                    align_err  = (addr_lo != 2'd0);
                end
                default: align_err = 1'b1;
            endcase
        end else begin
            case (func3)
                F3Lb:  load_data = sext8(byte_sel);
                F3Lbu: load_data = {24'd0, byte_sel};
                F3Lh: begin
                    load_data = sext16(half_sel);
                    align_err = addr_lo[0];
                end
                F3Lhu: begin
                    load_data = {16'd0, half_sel};
                    align_err = addr_lo[0];
                end
                F3Lw: begin
                    load_data = rword;
                    align_err = (addr_lo != 2'd0);
                end
                default: align_err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/r200dmem_resp.sv
// MEM-stage data-memory responder: one request at a time, WAIT wait states, then a
// held response carrying extended load data or a store acknowledge.
module r200dmem_resp
    import r200dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [3:0]  WaitInit  = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
    localparam logic [32:0] AddrLimit = 33'(DEPTH) << 2;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, op;
    logic        latch, do_access;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] widx;
    logic [31:0] rword, load_data, store_word;
    logic [3:0]  store_be;
    logic        align_err, range_err, err, mem_we;

    // With WAIT = 0 the access happens on the accept edge, before req_q is loaded.
    always_comb begin
        op = req_q;
        if (state_q == StIdle) begin
            op = '{we: req_we, func3: req_func3, addr: req_addr, wdata: req_wdata};
        end
    end

    assign widx      = op.addr[AW+1:2];
    assign rword     = mem[widx];
    assign range_err = ({1'b0, op.addr} >= AddrLimit);
    assign err       = align_err | range_err;
    assign mem_we    = rst & do_access & op.we & ~err;

    r200lsu_align u_align (
        .we        (op.we),
        .func3     (op.func3),
        .addr_lo   (op.addr[1:0]),
        .wdata     (op.wdata),
        .rword     (rword),
        .load_data (load_data),
        .store_word(store_word),
        .store_be  (store_be),
        .align_err (align_err)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        do_access = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    latch = 1'b1;
                    if (WAIT == 0) begin
                        state_d   = StResp;
                        do_access = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d   = StResp;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                req_q <= op;
            end
            if (do_access) begin
                err_q   <= err;
                rdata_q <= (err || op.we) ? 32'd0 : load_data;
            end
        end
    end

    // Contents survive reset; only the byte lanes selected by store_be change.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (store_be[i]) begin
                    mem[widx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = rst & (state_q == StIdle);
    assign resp_valid = rst & (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_r200dmem_resp.sv
// Directed bench for r200dmem_resp: a WAIT=2 instance for the access tests and a
// WAIT=0 instance for backpressure.
module tb_r200dmem_resp;

    logic clk = 1'b0;
    logic rst;

    logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
    logic [2:0]  a_req_func3;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
    logic [2:0]  b_req_func3;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    r200dmem_resp #(.DEPTH(1024), .WAIT(2)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_we    (a_req_we),
        .req_func3 (a_req_func3),
        .req_addr  (a_req_addr),
        .req_wdata (a_req_wdata),
        .resp_valid(a_resp_valid),
        .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata),
        .resp_err  (a_resp_err)
    );

    r200dmem_resp #(.DEPTH(1024), .WAIT(0)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_we    (b_req_we),
        .req_func3 (b_req_func3),
        .req_addr  (b_req_addr),
        .req_wdata (b_req_wdata),
        .resp_valid(b_resp_valid),
        .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata),
        .resp_err  (b_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Issue one request on instance A; inputs are scrambled after accept.
    task automatic a_xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        int n;
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_func3 = f3;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        n = 0;
        while (!a_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        a_req_addr  = addr ^ 32'h4;
        a_req_wdata = ~wdata;
        a_req_func3 = 3'b111;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!a_resp_valid && lat < 40);
        rdata = a_resp_rdata;
        err   = a_resp_err;
    endtask

    task automatic a_chk(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        a_xfer(we, f3, addr, wdata, rdata, err, lat);
        check({tag, ".rdata"}, rdata, exp_rdata);
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        check({tag, ".lat"}, 32'(lat), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b0;
        a_req_valid  = 1'b0;
        a_req_we     = 1'b0;
        a_req_func3  = 3'b000;
        a_req_addr   = 32'd0;
        a_req_wdata  = 32'd0;
        a_resp_ready = 1'b1;
        b_req_valid  = 1'b0;
        b_req_we     = 1'b0;
        b_req_func3  = 3'b000;
        b_req_addr   = 32'd0;
        b_req_wdata  = 32'd0;
        b_resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst.req_ready", 32'(a_req_ready), 32'd0);
        check("rst.resp_valid", 32'(a_resp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel.req_ready", 32'(a_req_ready), 32'd1);
        check("rel.rdata", a_resp_rdata, 32'd0);
        check("rel.err", 32'(a_resp_err), 32'd0);
        check("rel.b_req_ready", 32'(b_req_ready), 32'd1);

        a_chk("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        a_chk("lw10", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

        a_chk("sw20", 1'b1, 3'b010, 32'h20, 32'h0000_0000, 32'd0, 1'b0);
        a_chk("sb21", 1'b1, 3'b000, 32'h21, 32'h0000_0080, 32'd0, 1'b0);
        a_chk("lb21", 1'b0, 3'b000, 32'h21, 32'd0, 32'hFFFF_FF80, 1'b0);
        a_chk("lbu21", 1'b0, 3'b100, 32'h21, 32'd0, 32'h0000_0080, 1'b0);
        a_chk("lw20", 1'b0, 3'b010, 32'h20, 32'd0, 32'h0000_8000, 1'b0);
        a_chk("lh20", 1'b0, 3'b001, 32'h20, 32'd0, 32'hFFFF_8000, 1'b0);
        a_chk("lhu20", 1'b0, 3'b101, 32'h20, 32'd0, 32'h0000_8000, 1'b0);

        a_chk("sw22mis", 1'b1, 3'b010, 32'h22, 32'h1234_5678, 32'd0, 1'b1);
        a_chk("lw20post", 1'b0, 3'b010, 32'h20, 32'd0, 32'h0000_8000, 1'b0);
        a_chk("lh21mis", 1'b0, 3'b001, 32'h21, 32'd0, 32'd0, 1'b1);
        a_chk("lw1000oor", 1'b0, 3'b010, 32'h1000, 32'd0, 32'd0, 1'b1);
        a_chk("ld011", 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1);
        a_chk("st100", 1'b1, 3'b100, 32'h10, 32'h5555_5555, 32'd0, 1'b1);
        a_chk("lw10keep", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

        // Reset while a store sits in WAIT: memory keeps its old value.
        a_chk("sw40", 1'b1, 3'b010, 32'h40, 32'h1111_1111, 32'd0, 1'b0);
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_we    = 1'b1;
        a_req_func3 = 3'b010;
        a_req_addr  = 32'h40;
        a_req_wdata = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstw.resp_valid", 32'(a_resp_valid), 32'd0);
            check("rstw.req_ready", 32'(a_req_ready), 32'd0);
        end
        rst = 1'b1;
        a_chk("lw40", 1'b0, 3'b010, 32'h40, 32'd0, 32'h1111_1111, 1'b0);

        // WAIT=0 instance: latency of one cycle, then backpressure.
        @(negedge clk);
        b_req_valid = 1'b1;
        b_req_we    = 1'b1;
        b_req_func3 = 3'b010;
        b_req_addr  = 32'h4;
        b_req_wdata = 32'h0000_CAFE;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        check("b.sw.valid", 32'(b_resp_valid), 32'd1);
        check("b.sw.err", 32'(b_resp_err), 32'd0);

        @(negedge clk);
        b_resp_ready = 1'b0;
        b_req_valid  = 1'b1;
        b_req_we     = 1'b0;
        b_req_func3  = 3'b010;
        b_req_addr   = 32'h4;
        @(posedge clk);
        #1;
        b_req_addr  = 32'h1001;
        b_req_func3 = 3'b011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.valid", 32'(b_resp_valid), 32'd1);
            check("bp.rdata", b_resp_rdata, 32'h0000_CAFE);
            check("bp.err", 32'(b_resp_err), 32'd0);
            check("bp.req_ready", 32'(b_req_ready), 32'd0);
        end
        b_resp_ready = 1'b1;
        b_req_valid  = 1'b0;
        @(negedge clk);
        check("bp.rel.req_ready", 32'(b_req_ready), 32'd1);
        check("bp.rel.valid", 32'(b_resp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
